// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between NUM_REQ requesters.
// Optional divide-by-zero flag output resp_err enabled by defining ALU_RR_SCHEDULER_ERR_EN.
module alu_rr_scheduler #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_oc,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          busy
`ifdef ALU_RR_SCHEDULER_ERR_EN
  ,
  output logic                          resp_err
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              oc_q, oc_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
`ifdef ALU_RR_SCHEDULER_ERR_EN
  logic                    err_q, err_d;
`endif

  logic [IdxW-1:0]         win_idx;
  logic                    win_found;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [2:0]              win_oc;

  // Scan from the farthest offset down so the nearest valid requester after last_q wins.
  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] idx_n;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    idx_n     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(last_q) + (NUM_REQ - k)) % NUM_REQ;
      idx_n = IdxW'(idx);
      if (req_valid[idx_n]) begin
        win_idx   = idx_n;
        win_found = 1'b1;
      end
    end
  end

  assign win_oc = req_oc[3*win_idx +: 3];

  // Shared ALU: fed only from the captured operand registers.
  always_comb begin
    alu_res = '0;
    case (oc_q)
      3'b000:  alu_res = a_q + b_q;
      3'b001:  alu_res = a_q - b_q;
      3'b010:  alu_res = a_q * b_q;
      3'b011:  if (b_q != '0) alu_res = a_q / b_q;
      3'b100:  alu_res = ~a_q;
      3'b101:  alu_res = a_q ^ b_q;
      3'b110:  alu_res = a_q | b_q;
      3'b111:  alu_res = a_q & b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    oc_d         = oc_q;
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
`ifdef ALU_RR_SCHEDULER_ERR_EN
    err_d        = err_q;
`endif
    req_ready    = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          oc_d    = win_oc;
          a_d     = req_a[DATA_WIDTH*win_idx +: DATA_WIDTH];
          b_d     = req_b[DATA_WIDTH*win_idx +: DATA_WIDTH];
          owner_d = win_idx;
          cnt_d   = (win_oc[2:1] == 2'b01) ? CntW'(MULDIV_CYCLES - 1) : '0;
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          resp_data_d           = alu_res;
          resp_valid_d          = '0;
          resp_valid_d[owner_q] = 1'b1;
`ifdef ALU_RR_SCHEDULER_ERR_EN
          err_d                 = (oc_q == 3'b011) && (b_q == '0);
`endif
          state_d               = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready[owner_q]) begin
          resp_valid_d = '0;
          last_d       = owner_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      oc_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= '0;
      last_q       <= IdxW'(NUM_REQ - 1);
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
`ifdef ALU_RR_SCHEDULER_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      oc_q         <= oc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
`ifdef ALU_RR_SCHEDULER_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != StIdle);
`ifdef ALU_RR_SCHEDULER_ERR_EN
  assign resp_err   = err_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed table, corner sequences, random traffic.
module tb_alu_rr_scheduler;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MC = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [3*N-1:0] req_oc;
  logic [W*N-1:0] req_a, req_b;
  logic [W-1:0]   resp_data;
  logic           busy;
`ifdef ALU_RR_SCHEDULER_ERR_EN
  logic           resp_err;
`endif

  alu_rr_scheduler #(.DATA_WIDTH(W), .NUM_REQ(N), .MULDIV_CYCLES(MC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_oc     (req_oc),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
`ifdef ALU_RR_SCHEDULER_ERR_EN
    .resp_err   (resp_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_last;
  logic [2:0] tb_oc [N];
  logic [W-1:0] tb_a [N];
  logic [W-1:0] tb_b [N];

  typedef struct {
    int         r;
    logic [2:0] oc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int         stall;
    logic [W-1:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] oc, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned r;
    case (oc)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x * y;
      3'd3: r = (y == 0) ? 0 : x / y;
      3'd4: r = ~x;
      3'd5: r = x ^ y;
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r[W-1:0];
  endfunction

  function automatic int ref_winner(input logic [N-1:0] v, input int last);
    for (int d = 1; d <= N; d++) begin
      if (v[(last + d) % N]) return (last + d) % N;
    end
    return -1;
  endfunction

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      req_oc[3*i +: 3] = tb_oc[i];
      req_a[W*i +: W]  = tb_a[i];
      req_b[W*i +: W]  = tb_b[i];
    end
  endtask

  task automatic scramble();
    req_valid = N'($urandom);
    req_oc    = (3*N)'($urandom);
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_oc     = '0;
    req_a      = '0;
    req_b      = '0;
    step();
    step();
    rst    = 1'b0;
    m_last = N - 1;
  endtask

  // One full transaction starting in IDLE; returns granted index and the response data seen.
  task automatic run_txn(input logic [N-1:0] vmask, input int stall, input logic [N-1:0] next_v,
                         output int won, output logic [W-1:0] got);
    int w, lat;
    logic [N-1:0] oh;
    logic [2:0] e_oc;
    logic [W-1:0] e_a, e_b, e_d;
    pack_inputs();
    req_valid  = vmask;
    resp_ready = '0;
    w = ref_winner(vmask, m_last);
    oh = N'(1) << w;
    #1;
    chk("grant_onehot", 32'(req_ready), 32'(oh));
    won = -1;
    for (int i = N - 1; i >= 0; i--) if (req_ready[i]) won = i;
    e_oc = tb_oc[w];
    e_a  = tb_a[w];
    e_b  = tb_b[w];
    e_d  = ref_alu(e_oc, e_a, e_b);
    lat  = (e_oc == 3'd2 || e_oc == 3'd3) ? MC : 1;
    step();
    for (int k = 1; k <= lat; k++) begin
      scramble();
      #1;
      chk("exec_no_ready", 32'(req_ready), 32'(0));
      chk("exec_no_resp", 32'(resp_valid), 32'(0));
      step();
    end
    chk("resp_valid", 32'(resp_valid), 32'(oh));
    chk("resp_data", 32'(resp_data), 32'(e_d));
`ifdef ALU_RR_SCHEDULER_ERR_EN
    chk("resp_err", 32'(resp_err), 32'((e_oc == 3'd3) && (e_b == '0)));
`endif
    got = resp_data;
    for (int s = 0; s < stall; s++) begin
      resp_ready = ~oh;
      step();
      chk("stall_valid", 32'(resp_valid), 32'(oh));
      chk("stall_data", 32'(resp_data), 32'(e_d));
      chk("stall_busy", 32'(busy), 32'(1));
    end
    resp_ready = oh | N'($urandom);
    req_valid  = next_v;
    step();
    chk("done_idle", 32'(busy), 32'(0));
    chk("done_no_resp", 32'(resp_valid), 32'(0));
    m_last = w;
  endtask

  initial begin
    vec_t vt[13];
    int rr_exp[5];
    int won;
    logic [W-1:0] got;

    vt[0]  = '{0, 3'b000, 16'h0005, 16'h0003, 0, 16'h0008};
    vt[1]  = '{2, 3'b010, 16'd7,    16'd6,    0, 16'd42};
    vt[2]  = '{1, 3'b001, 16'd3,    16'd5,    5, 16'hFFFE};
    vt[3]  = '{3, 3'b011, 16'd100,  16'd0,    0, 16'h0000};
    vt[4]  = '{3, 3'b011, 16'd100,  16'd7,    0, 16'd14};
    vt[5]  = '{0, 3'b100, 16'h00FF, 16'h1234, 1, 16'hFF00};
    vt[6]  = '{1, 3'b101, 16'hF0F0, 16'h0FF0, 0, 16'hFF00};
    vt[7]  = '{2, 3'b110, 16'h1200, 16'h0034, 2, 16'h1234};
    vt[8]  = '{3, 3'b111, 16'hF0F0, 16'h3C3C, 0, 16'h3030};
    vt[9]  = '{0, 3'b000, 16'hFFFF, 16'h0001, 0, 16'h0000};
    vt[10] = '{1, 3'b010, 16'h1234, 16'h0100, 0, 16'h3400};
    vt[11] = '{2, 3'b001, 16'h0000, 16'h0001, 3, 16'hFFFF};
    vt[12] = '{1, 3'b011, 16'hFFFF, 16'h0010, 0, 16'h0FFF};
    rr_exp = '{0, 1, 2, 3, 0};

    do_reset();
    #1;
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(resp_valid), 32'(0));
    chk("rst_data", 32'(resp_data), 32'(0));
`ifdef ALU_RR_SCHEDULER_ERR_EN
    chk("rst_err", 32'(resp_err), 32'(0));
`endif

    // Round robin from reset with all requesters continuously valid.
    for (int i = 0; i < N; i++) begin
      tb_oc[i] = 3'b000;
      tb_a[i]  = W'(i);
      tb_b[i]  = 16'd10;
    end
    for (int g = 0; g < 5; g++) begin
      run_txn('1, 0, '1, won, got);
      chk("rr_order", 32'(won), 32'(rr_exp[g]));
    end

    // Directed vector table, one requester at a time.
    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < N; i++) begin
        tb_oc[i] = 3'($urandom);
        tb_a[i]  = W'($urandom);
        tb_b[i]  = W'($urandom);
      end
      tb_oc[vt[v].r] = vt[v].oc;
      tb_a[vt[v].r]  = vt[v].a;
      tb_b[vt[v].r]  = vt[v].b;
      run_txn(N'(1) << vt[v].r, vt[v].stall, '0, won, got);
      chk("vec_grant", 32'(won), 32'(vt[v].r));
      chk("vec_data", 32'(got), 32'(vt[v].exp));
    end

    // Reset during the second execute cycle of a multiply.
    tb_oc[2] = 3'b010;
    tb_a[2]  = 16'd7;
    tb_b[2]  = 16'd6;
    pack_inputs();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    chk("mid_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_valid", 32'(resp_valid), 32'(0));
    chk("abort_data", 32'(resp_data), 32'(0));
    m_last = N - 1;
    for (int c = 0; c < MC + 2; c++) begin
      step();
      chk("abort_quiet", 32'(resp_valid), 32'(0));
    end
    run_txn('1, 0, '0, won, got);
    chk("abort_regrant", 32'(won), 32'(0));

    // Randomized traffic against the transaction-level model.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        req_valid = '0;
        #1;
        chk("idle_ready", 32'(req_ready), 32'(0));
        step();
        chk("idle_busy", 32'(busy), 32'(0));
      end
      for (int i = 0; i < N; i++) begin
        tb_oc[i] = 3'($urandom_range(0, 7));
        tb_a[i]  = W'($urandom);
        tb_b[i]  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      end
      run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3), N'($urandom), won,
              got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational ALU instance (16-bit default, 3-bit opcode) between NUM_REQ requesters.
- Uses round-robin arbitration, a valid/ready request handshake, and a registered, back-pressurable response.
- Models multiply and divide as multi-cycle operations: operands are held stable for MULDIV_CYCLES cycles before the result is captured.
- Sits between client FSMs and the shared arithmetic unit.

Parameters:
- DATA_WIDTH, 16, operand/result width; passed through to the ALU instance.
- NUM_REQ, 4, number of requesters (2..8).
- MULDIV_CYCLES, 4, execute cycles for oc 010 (mul) and 011 (div); minimum 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot accept; combinational, IDLE only.
- req_oc  input  3*NUM_REQ  opcodes; requester i uses bits [3i+2:3i].
- req_a  input  DATA_WIDTH*NUM_REQ  operand a, packed the same way.
- req_b  input  DATA_WIDTH*NUM_REQ  operand b, packed the same way.
- resp_valid  output  NUM_REQ  one-hot response valid, addressed to the owner.
- resp_ready  input  NUM_REQ  per-requester response accept.
- resp_data  output  DATA_WIDTH  registered ALU result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Single internal ALU instance. Opcodes:
  - 000 add, 001 sub, 010 mul, 011 div (result 0 when b==0).
  - 100 not a, 101 xor, 110 or, 111 and.
  - All results truncated to DATA_WIDTH.
- FSM states: IDLE, EXEC, RESP.
- Reset:
  - state=IDLE, resp_valid=0, resp_data=0, busy=0.
  - Captured oc/a/b=0, owner=0.
  - last_grant=NUM_REQ-1, so requester 0 has priority first.
  - Reset mid-EXEC or mid-RESP aborts the operation: no response is issued and the result is discarded.
- IDLE:
  - Winner = first requester with req_valid set, searching from last_grant+1 upward with wrap-around.
  - req_ready[winner]=1 in the same cycle; all other bits are 0.
  - On that edge: capture oc/a/b/owner.
  - Load cnt = MULDIV_CYCLES-1 for oc 010/011, else 0.
  - Go to EXEC.
  - No req_valid: stay in IDLE with req_ready=0.
- EXEC:
  - req_ready=0.
  - ALU inputs are driven only from the captured registers; requester inputs may change freely.
  - If cnt==0: resp_data <= ALU result, resp_valid[owner] <= 1, go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - resp_valid one-hot on owner; resp_data held stable.
  - When resp_ready[owner]=1: clear resp_valid, set last_grant=owner, go to IDLE.
  - resp_ready bits of non-owners are ignored.
- Latency:
  - Handshake edge T.
  - resp_valid asserted after edge T+1 for single-cycle ops.
  - resp_valid asserted after edge T+MULDIV_CYCLES for mul/div.
- Throughput: at most one operation in flight. Minimum 3 cycles per op (IDLE, EXEC, RESP) with resp_ready held high.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 grants.
- last_grant updates only on response completion.
- Simultaneous events: a requester may assert a new req_valid in the same cycle its response is accepted. It is considered in the next IDLE cycle, at lowest priority.
- req_valid is not required to stay high; a dropped request is simply not granted.

Optional Feature:
- Macro: ALU_RR_SCHEDULER_ERR_EN.
- When defined:
  - Adds output resp_err (1 bit), registered alongside resp_data.
  - resp_err=1 when the captured oc==011 and b==0 (resp_data is 0); otherwise 0.
  - Valid only while resp_valid is non-zero; reset value 0.
- When undefined: no port and no logic. Divide-by-zero returns 0 silently.

Test Plan:
- Single add: req0 oc=000, a=16'h0005, b=16'h0003, resp_ready=1 -> req_ready[0] in the request cycle; resp_valid=4'b0001 and resp_data=16'h0008 two edges later.
- Mul latency: req2 oc=010, a=7, b=6, MULDIV_CYCLES=4 -> resp_valid=4'b0100 exactly 4 edges after handshake; resp_data=42.
- Round-robin: all four requesters hold req_valid with resp_ready=4'b1111 from reset -> grant order 0,1,2,3,0 with no requester skipped.
- Backpressure: req1 oc=001, a=3, b=5, resp_ready[1]=0 for 5 cycles ->
  - resp_data=16'hFFFE held stable and busy=1 throughout.
  - Asserting resp_ready[0] during the stall has no effect.
  - Release resp_ready[1] -> return to IDLE.
- Divide by zero: req3 oc=011, a=100, b=0 -> resp_data=0; with ALU_RR_SCHEDULER_ERR_EN, resp_err=1. Then a=100, b=7 -> resp_data=14, resp_err=0.
- Reset mid-EXEC: rst asserted during the 2nd execute cycle of a mul -> next cycle state=IDLE, resp_valid=0, resp_data=0; req0 wins the next grant.
